muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource used by the MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO instructions.
- Accepts one operation from EX and runs a fixed-latency multiply or an iterative 1-bit/cycle divide.
- Owns the architectural HI/LO registers.
- Raises a stall so the pipeline holds while the unit is busy and a dependent op or HI/LO read arrives.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/div_iter_core.sv | 20 ++
 rtl/muldiv_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned CNT_W           = 5;
  localparam int unsigned DIV_BUSY_CYCLES = 34;
  localparam int unsigned DIV_ITERS       = DIV_BUSY_CYCLES - 2;

  localparam logic [2:0]  OP_MULT  = 3'd0;
  localparam logic [2:0]  OP_MULTU = 3'd1;
  localparam logic [2:0]  OP_DIV   = 3'd2;
  localparam logic [2:0]  OP_DIVU  = 3'd3;
  localparam logic [2:0]  OP_MTHI  = 3'd4;
  localparam logic [2:0]  OP_MTLO  = 3'd5;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX
  } state_e;

  // Two's-complement negate when neg is set (magnitude / sign restore).
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? 32'(-v) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// One restoring-divide step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference if non-negative and shift in the quotient bit.
module div_iter_core (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted_c;
  logic [32:0] diff_c;

  // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
  assign shifted_c = {rem_i, quo_i[31]};
  assign diff_c    = shifted_c - {1'b0, dvs_i};
  assign rem_o     = diff_c[32] ? shifted_c[31:0] : diff_c[31:0];
  assign quo_o     = {quo_i[30:0], ~diff_c[32]};

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 1-bit/cycle
// restoring divide, MTHI/MTLO writes and pipeline stall generation.
// Optional: define MULDIV_CANCEL_EN to add a 'cancel' input that aborts an
// in-flight operation (and blocks an accept) for exception flush.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4  // legal 1..8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mf_req,
`ifdef MULDIV_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        dvd_q, dvd_d;
  logic [31:0]        dvs_q, dvs_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cancel_c;
  logic               accept_c;
  logic [63:0]        mul_a_ext_c;
  logic [63:0]        mul_b_ext_c;
  logic [63:0]        prod_c;
  logic [31:0]        step_rem_c;
  logic [31:0]        step_quo_c;
  logic               quo_neg_c;
  logic               rem_neg_c;

`ifdef MULDIV_CANCEL_EN
  assign cancel_c = cancel;
`else
  assign cancel_c = 1'b0;
`endif

  // Sign-extend for MULT so one 64-bit multiply serves both flavours.
  assign mul_a_ext_c = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b_ext_c = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod_c      = mul_a_ext_c * mul_b_ext_c;

  assign quo_neg_c = sgn_q & (a_q[31] ^ b_q[31]);
  assign rem_neg_c = sgn_q & a_q[31];

  div_iter_core u_div_iter_core (
    .rem_i (rem_q),
    .quo_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_c),
    .quo_o (step_quo_c)
  );

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    accept_c = op_valid && !busy_q && (op <= OP_MTLO) && !cancel_c;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          case (op)
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            OP_MULT, OP_MULTU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = src_a;
              b_d     = src_b;
              sgn_d   = (op == OP_DIV);
              state_d = DIV_PREP;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod_c;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_PREP: begin
        dvd_d   = mag32(a_q, sgn_q & a_q[31]);
        dvs_d   = mag32(b_q, sgn_q & b_q[31]);
        rem_d   = '0;
        cnt_d   = CNT_W'(DIV_ITERS - 1);
        state_d = DIV_ITER;
      end
      DIV_ITER: begin
        rem_d = step_rem_c;
        dvd_d = step_quo_c;
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV_FIX: begin
        // Divide by zero reports all-ones quotient and the untouched dividend.
        if (b_q == '0) begin
          lo_d = DIV0_QUOT;
          hi_d = a_q;
        end else begin
          lo_d = mag32(dvd_q, quo_neg_c);
          hi_d = mag32(rem_q, rem_neg_c);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush: drop the in-flight op without touching HI/LO.
    if (cancel_c && busy_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != IDLE);
    done_d = ((state_d == MUL) && (cnt_d == '0)) || (state_d == DIV_FIX);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q & (op_valid | mf_req);
  assign hi    = hi_q;
  assign lo    = lo_q;
`ifdef MULDIV_CANCEL_EN
  assign done  = done_q & ~cancel_c;
`else
  assign done  = done_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl against an arithmetic HI/LO model.
// Define MULDIV_CANCEL_EN to also exercise the cancel port.
module tb_muldiv_ctrl;

  localparam int unsigned MUL_CYC = 4;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mf_req;
`ifdef MULDIV_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .mf_req   (mf_req),
`ifdef MULDIV_CANCEL_EN
    .cancel   (cancel),
`endif
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // Architectural result of one op from plain arithmetic; lat = busy cycles.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = hi_m;
    el = lo_m;
    lat = 0;
    case (o)
      3'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; lat = MUL_CYC; end
      3'd1: begin up = ua * ub; p = up; eh = p[63:32]; el = p[31:0]; lat = MUL_CYC; end
      3'd2: begin
        lat = DIV_LAT;
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin sq = sa / sb; sr = sa % sb; el = 32'(sq); eh = 32'(sr); end
      end
      3'd3: begin
        lat = DIV_LAT;
        if (b == 0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = 32'(ua / ub); eh = 32'(ua % ub); end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // Issue one op in an idle cycle and follow it to completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el, old_h, old_l;
    int lat, nbusy, done_at, ndone;
    bit hold_bad, stall_bad;
    model(o, a, b, eh, el, lat);
    old_h = hi_m;
    old_l = lo_m;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; mf_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_before busy=%b stall=%b required 0/0", tag, busy, stall);
    end
    nbusy = 0; done_at = -1; ndone = 0; hold_bad = 0; stall_bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      if (busy !== 1'b1) break;
      nbusy++;
      if (done === 1'b1) begin ndone++; done_at = nbusy; end
      if (hi !== old_h || lo !== old_l) hold_bad = 1;
      if (stall !== 1'b0) stall_bad = 1;
    end
    checks++;
    if (nbusy != lat || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_cycles got=%0d busy_now=%b required=%0d", tag, nbusy, busy, lat);
    end
    checks++;
    if ((lat > 0 && (ndone != 1 || done_at != lat)) || (lat == 0 && ndone != 0) || done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse count=%0d at=%0d required_at=%0d", tag, ndone, done_at, lat);
    end
    checks++;
    if (hold_bad || stall_bad) begin
      failures++;
      $display("FAIL %s hold_during_busy hi_lo_changed=%0d stall_seen=%0d required 0/0",
               tag, hold_bad, stall_bad);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL %s result hi=%h lo=%h required hi=%h lo=%h", tag, hi, lo, eh, el);
    end
    hi_m = eh;
    lo_m = el;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op = '0; src_a = '0; src_b = '0; mf_req = 1'b0;
`ifdef MULDIV_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; mf_req = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b stall=%b required 0/0/0", busy, done, stall);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo hi=%h lo=%h required 0/0", hi, lo);
    end
    mf_req = 1'b0;
    hi_m = '0; lo_m = '0;
  endtask

  // Directed corner cases with hand-derived HI/LO values.
  task automatic test_directed;
    logic [2:0]  t_op [12] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd6, 3'd4};
    logic [31:0] t_a  [12] = '{32'h1234_5678, 32'hCAFE_F00D, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                               32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'hFFFF_FFFB,
                               32'd7, 32'd1, 32'h0BAD_BEEF};
    logic [31:0] t_b  [12] = '{32'd0, 32'd0, 32'd3, 32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF,
                               32'd0, 32'hFFFF_FFFE, 32'd1, 32'd0};
    logic [31:0] t_hi [12] = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF,
                               32'd2, 32'd5, 32'd0, 32'hFFFF_FFFB, 32'd1, 32'd1, 32'h0BAD_BEEF};
    logic [31:0] t_lo [12] = '{32'd0, 32'hCAFE_F00D, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD,
                               32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    for (int i = 0; i < 12; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], $sformatf("directed%0d", i));
      checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        failures++;
        $display("FAIL directed%0d_const hi=%h lo=%h required hi=%h lo=%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
    end
  endtask

  // mf_req and a second MULT arrive mid-MULTU: stall, then accept after done.
  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2, eh, el;
    logic exp_stall;
    int lat, nbusy;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd1; src_a = a1; src_b = b1; mf_req = 1'b0;
    model(3'd1, a1, b1, eh, el, lat);
    for (int c = 1; c <= int'(MUL_CYC) + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin op_valid = 1'b0; mf_req = 1'b0; end
      else if (c == 2) begin op_valid = 1'b1; op = 3'd0; src_a = a2; src_b = b2; mf_req = 1'b1; end
      #1;
      exp_stall = (c >= 2 && c <= int'(MUL_CYC));
      checks++;
      if (stall !== exp_stall) begin
        failures++;
        $display("FAIL b2b_stall cycle=T+%0d stall=%b required=%b", c, stall, exp_stall);
      end
    end
    checks++;
    if (busy !== 1'b0 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL b2b_first busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h", busy, hi, lo, eh, el);
    end
    hi_m = eh; lo_m = el;
    model(3'd0, a2, b2, eh, el, lat);
    nbusy = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      op_valid = 1'b0; mf_req = 1'b0;
      #1;
      if (busy !== 1'b1) break;
      nbusy++;
    end
    checks++;
    if (nbusy != lat || busy !== 1'b0 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL b2b_second busy_cycles=%0d hi=%h lo=%h required %0d hi=%h lo=%h",
               nbusy, hi, lo, lat, eh, el);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic test_random;
    logic [31:0] corner [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b;
    logic [2:0]  o;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      run_op(o, a, b, $sformatf("random%0d_op%0d", i, o));
    end
  endtask

  // Reset part-way through a MULT and a DIV clears HI/LO and idles the unit.
  task automatic test_reset_midop;
    logic [2:0] ops [2] = '{3'd0, 3'd2};
    int when [2] = '{2, 20};
    for (int k = 0; k < 2; k++) begin
      run_op(3'd4, $urandom | 32'h1, 32'd0, "pre_rst_mthi");
      @(posedge clk); #1;
      op_valid = 1'b1; op = ops[k]; src_a = $urandom; src_b = $urandom | 32'h1;
      for (int c = 1; c <= when[k]; c++) begin
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (c == when[k]) rst = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        failures++;
        $display("FAIL rst_mid%0d busy=%b done=%b hi=%h lo=%h required 0/0/0/0", k, busy, done, hi, lo);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        failures++;
        $display("FAIL rst_mid%0d_after busy=%b hi=%h lo=%h required 0/0/0", k, busy, hi, lo);
      end
      hi_m = '0; lo_m = '0;
    end
  endtask

`ifdef MULDIV_CANCEL_EN
  task automatic test_cancel;
    bit saw_done;
    run_op(3'd4, 32'hA5A5_0001, 32'd0, "cancel_pre_hi");
    run_op(3'd5, 32'h5A5A_0002, 32'd0, "cancel_pre_lo");
    saw_done = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd2; src_a = $urandom; src_b = $urandom | 32'h1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      op_valid = 1'b0;
      if (c == 10) cancel = 1'b1;
      #1;
      if (done === 1'b1) saw_done = 1;
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || saw_done || hi !== hi_m || lo !== lo_m) begin
      failures++;
      $display("FAIL cancel_div busy=%b done_seen=%0d hi=%h lo=%h required 0/0 hi=%h lo=%h",
               busy, saw_done, hi, lo, hi_m, lo_m);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (hi !== hi_m || lo !== lo_m) begin
      failures++;
      $display("FAIL cancel_late_write hi=%h lo=%h required hi=%h lo=%h", hi, lo, hi_m, lo_m);
    end
    op_valid = 1'b1; op = 3'd4; src_a = 32'hDEAD_0000; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; cancel = 1'b0;
    #1;
    checks++;
    if (hi !== hi_m || busy !== 1'b0) begin
      failures++;
      $display("FAIL cancel_mthi hi=%h busy=%b required hi=%h busy=0", hi, busy, hi_m);
    end
    run_op(3'd3, 32'd100, 32'd7, "post_cancel_divu");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midop();
`ifdef MULDIV_CANCEL_EN
    test_cancel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
